serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial ripple adder that consumes the half-adder primitive one stage downstream. Two half adders plus an OR form a full-adder cell. A single carry flip-flop chains that cell across WIDTH clock cycles. Operands are accepted on a valid/ready input handshake, processed LSB-first, and the WIDTH-bit sum plus carry-out is presented on a valid/ready output handshake. It is the area-minimal adder for datapaths where latency is acceptable.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1 to 64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for the bit-0 add.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result, equal to (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered carry out of bit WIDTH-1.
- busy  output  1  high in the RUN or DONE state.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low, per the already-decided requirement.
- Reset values: state = IDLE; a_sr, b_sr, sum_sr, carry and bit counter all 0. This gives out_valid=0, sum=0, cout=0, busy=0 and in_ready=1 while reset is asserted and after it is released.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE). out_valid = (state==DONE). These are decoded from registered state; there is no combinational path from in_valid or out_ready to any output.
- IDLE:
  - An accept occurs on an edge with in_valid && in_ready.
  - On accept: a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, sum_sr<=0, state->RUN.
  - a, b and cin are sampled only at accept.
- RUN, on each edge:
  - Full-adder cell computes s, co from a_sr[0], b_sr[0], carry.
  - carry<=co.
  - a_sr and b_sr shift right by 1.
  - sum_sr<={s, sum_sr[WIDTH-1:1]}, so bit 0 lands in sum_sr[0] after WIDTH shifts.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1, state->DONE on that same edge.
- DONE:
  - sum = sum_sr and cout = carry, held stable while out_ready is low (indefinite backpressure is allowed).
  - On out_valid && out_ready: state->IDLE. Registers keep their values until the next accept.
- Latency: out_valid rises exactly WIDTH edges after the accept edge.
- Throughput: with out_ready tied high and in_valid held high, one result every WIDTH+2 cycles (accept edge, WIDTH RUN edges, handshake edge).
- in_valid while not IDLE: ignored, operands not consumed. The upstream must hold them until in_ready is seen.
- Arithmetic: unsigned. Counter width is $clog2(WIDTH+1), which also covers WIDTH=1. For WIDTH=1, RUN lasts exactly one edge.
- Overflow: wrap-around is reported only through cout; no saturation.
- Reset mid-operation: the operation is aborted and no out_valid is produced. Outputs return to their reset values immediately (asynchronous).
- Simultaneous events: none are possible, because the input and output handshakes are never open in the same state.

Decomposition:
- Shared package serial_adder_pkg:
  - state typedef (IDLE, RUN, DONE encoded as 2 bits).
  - SA_MAX_WIDTH=64 constant.
- Sub-module full_adder_cell:
  - two half_adder instances plus an OR for the carry.
  - purely combinational, instantiated once.
- Top level contains the FSM, shift registers, carry flop and counter.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x33, cin=0 -> sum=0x8D, cout=0. out_valid asserts exactly 8 edges after the accept edge; in_ready=0 and busy=1 meanwhile.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Checks carry ripple through all 8 bits.
3. a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Checks the cin path and maximum sum 0x1FF.
4. Hold out_ready=0 for 5 cycles after out_valid; present in_valid with a=0x01, b=0x01 during that time:
   - sum and cout stay constant, in_ready stays 0, and the new operands are not accepted.
   - After the handshake, the operands are accepted and 0x02 is produced.
5. Deassert rst_n during RUN at cnt=3 -> out_valid, sum and cout go to 0 immediately and in_ready goes to 1. After release, 0x10+0x20 gives sum=0x30, cout=0.
6. Back-to-back: in_valid and out_ready held at 1 for 4 operand pairs -> results every 10 cycles, matched against a reference model. Repeat with WIDTH=1: 1+1+cin=1 gives sum=1, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and limits for the bit-serial adder
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sa_state_e;

   localparam int SA_MAX_WIDTH = 64;

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - full adder built from two half adders and an OR
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic s0;
   logic c0;
   logic c1;

   half_adder u_ha0 (
      .a (a),
      .b (b),
      .s (s0),
      .c (c0)
   );

   half_adder u_ha1 (
      .a (s0),
      .b (ci),
      .s (s),
      .c (c1)
   );

   assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - one-bit half adder primitive
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder with valid/ready handshakes
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int             CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   if (WIDTH < 1 || WIDTH > SA_MAX_WIDTH) begin : g_bad_width
      $error("serial_adder: WIDTH out of range");
   end

   sa_state_e        state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] sum_shift;

   full_adder_cell u_fa (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   // New sum bits enter at the MSB so bit 0 settles in sum_q[0] after WIDTH shifts.
   if (WIDTH == 1) begin : g_w1
      assign sum_shift = fa_s;
   end else begin : g_wn
      assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
               sum_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            carry_d = fa_co;
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = sum_shift;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign sum       = sum_q;
   assign cout      = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder (WIDTH=8 and WIDTH=1)
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] a, b, sum;
   logic       cin, cout, busy;

   logic       in_valid1, in_ready1, out_valid1, out_ready1;
   logic [0:0] a1, b1, sum1;
   logic       cin1, cout1, busy1;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [8:0] sb[$];

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .a         (a1),
      .b         (b1),
      .cin       (cin1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .sum       (sum1),
      .cout      (cout1),
      .busy      (busy1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents operands, waits for in_ready, and records the model result on the accept edge.
   task automatic accept_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input bit keep);
      int k = 0;
      a = ta; b = tb; cin = tc; in_valid = 1'b1;
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("accept_wait", 64'(k < 100), 64'd1);
      @(posedge clk);
      sb.push_back({1'b0, ta} + {1'b0, tb} + 9'(tc));
      #1;
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      logic [8:0] e;
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 50) begin
         check("busy_run", 64'(busy), 64'd1);
         check("in_ready_run", 64'(in_ready), 64'd0);
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("result_timeout", 64'(lat < 50), 64'd1);
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check("sum", 64'(sum), 64'(e[7:0]));
         check("cout", 64'(cout), 64'(e[8]));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required $finish");
      $fatal(1);
   end

   initial begin
      int         lat;
      logic [7:0] ta[4], tb[4];
      logic       tc[4];
      logic [8:0] e;
      time        t_prev, t_out;
      logic [0:0] w1a[2], w1b[2];
      logic       w1c[2];

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
      in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Directed cases: plain add, full carry ripple, maximum sum with cin.
      ta[0] = 8'h5A; tb[0] = 8'h33; tc[0] = 1'b0;
      ta[1] = 8'hFF; tb[1] = 8'h01; tc[1] = 1'b0;
      ta[2] = 8'hFF; tb[2] = 8'hFF; tc[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         accept_op(ta[i], tb[i], tc[i], 1'b0);
         wait_result(lat);
         check("latency", 64'(lat), 64'd8);
         @(negedge clk);
         check("idle_in_ready", 64'(in_ready), 64'd1);
         check("idle_busy", 64'(busy), 64'd0);
      end

      // Backpressure with a competing request pending.
      out_ready = 1'b0;
      accept_op(8'hC3, 8'h3C, 1'b1, 1'b0);
      wait_result(lat);
      e = {1'b0, 8'hC3} + 9'h03C + 9'd1;
      a = 8'h01; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
      repeat (5) begin
         @(posedge clk); @(negedge clk);
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_sum", 64'(sum), 64'(e[7:0]));
         check("bp_cout", 64'(cout), 64'(e[8]));
         check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_in_ready", 64'(in_ready), 64'd1);
      accept_op(8'h01, 8'h01, 1'b0, 1'b0);
      wait_result(lat);
      check("bp_new_sum", 64'(sum), 64'h02);
      @(negedge clk);

      // Asynchronous reset while cnt==3: partial sum and carry are both nonzero here.
      accept_op(8'h06, 8'h03, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_sum", 64'(sum), 64'd0);
      check("abort_cout", 64'(cout), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      check("abort_busy", 64'(busy), 64'd0);
      e = sb.pop_back();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      accept_op(8'h10, 8'h20, 1'b0, 1'b0);
      wait_result(lat);
      check("post_abort_sum", 64'(sum), 64'h30);
      @(negedge clk);

      // Back-to-back with in_valid and out_ready held high.
      for (int i = 0; i < 4; i++) begin
         ta[i] = 8'($urandom);
         tb[i] = 8'($urandom);
         tc[i] = 1'($urandom);
      end
      t_prev = 0;
      for (int i = 0; i < 4; i++) begin
         accept_op(ta[i], tb[i], tc[i], 1'b1);
         wait_result(lat);
         t_out = $time;
         if (i > 0) check("b2b_period", 64'(t_out - t_prev), 64'd100);
         t_prev = t_out;
      end
      in_valid = 1'b0;
      @(negedge clk);
      check("sb_drained", 64'(sb.size()), 64'd0);

      // WIDTH=1 instance: RUN lasts a single edge.
      w1a[0] = 1'b1; w1b[0] = 1'b1; w1c[0] = 1'b1;
      w1a[1] = 1'b0; w1b[1] = 1'b1; w1c[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         e = 9'(w1a[i]) + 9'(w1b[i]) + 9'(w1c[i]);
         a1 = w1a[i]; b1 = w1b[i]; cin1 = w1c[i]; in_valid1 = 1'b1;
         check("w1_in_ready", 64'(in_ready1), 64'd1);
         @(posedge clk);
         #1 in_valid1 = 1'b0;
         @(negedge clk);
         check("w1_run_busy", 64'(busy1), 64'd1);
         check("w1_run_out_valid", 64'(out_valid1), 64'd0);
         @(negedge clk);
         check("w1_out_valid", 64'(out_valid1), 64'd1);
         check("w1_sum", 64'(sum1), 64'(e[0]));
         check("w1_cout", 64'(cout1), 64'(e[1]));
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
